// File: rtl/elevator_controller.sv
// Elevator car controller: latches floor calls, serves them with a collective
// (SCAN) policy, times floor-to-floor travel and the door hold, and drives the
// registered floor code / hold flag consumed by the floor display.
module elevator_controller #(
  parameter int NUM_FLOORS = 5,   // floors 0..NUM_FLOORS-1, at most 5
  parameter int MOVE_TICKS = 50,  // cycles to travel one floor (>= 2)
  parameter int HOLD_TICKS = 30   // cycles the door is held open (>= 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] req,
  output logic [2:0]            state,
  output logic                  hold,
  output logic                  moving_up,
  output logic                  moving_down,
  output logic [NUM_FLOORS-1:0] pending
);

  localparam int TMAX = (MOVE_TICKS > HOLD_TICKS) ? MOVE_TICKS : HOLD_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] MOVE_LAST = TW'(MOVE_TICKS - 1);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_TICKS - 1);
  localparam logic [2:0]    TOP       = 3'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_HOLD} fsm_t;

  // One-hot bit for floor f (loop compare keeps index widths independent of NUM_FLOORS).
  function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (3'(i) == f) m[i] = 1'b1;
    return m;
  endfunction

  // All floors strictly above f.
  function automatic logic [NUM_FLOORS-1:0] above_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (3'(i) > f) m[i] = 1'b1;
    return m;
  endfunction

  // All floors strictly below f.
  function automatic logic [NUM_FLOORS-1:0] below_mask(input logic [2:0] f);
    logic [NUM_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_FLOORS; i++) if (3'(i) < f) m[i] = 1'b1;
    return m;
  endfunction

  fsm_t                  fsm_q, fsm_d;
  logic                  dir_q, dir_d;        // 1 = up, 0 = down (last travel direction)
  logic [TW-1:0]         timer_q, timer_d;
  logic [2:0]            state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d;
  logic                  hold_q, moving_up_q, moving_down_q;

  logic [NUM_FLOORS-1:0] here, clear, req_eff;
  logic                  up_calls, dn_calls;
  logic [2:0]            nxt_up, nxt_dn;

  // Next-state: SCAN policy, travel/hold timing, call latch with served-bit clear.
  always_comb begin
    fsm_d    = fsm_q;
    dir_d    = dir_q;
    timer_d  = timer_q;
    state_d  = state_q;
    clear    = '0;
    req_eff  = req;
    here     = floor_bit(state_q);
    up_calls = |(pending_q & above_mask(state_q));
    dn_calls = |(pending_q & below_mask(state_q));
    nxt_up   = state_q + 3'd1;
    nxt_dn   = state_q - 3'd1;

    case (fsm_q)
      IDLE: begin
        timer_d = '0;
        if (|(pending_q & here)) begin
          fsm_d = DOOR_HOLD;
          clear = here;
        end else if (up_calls && (dir_q || !dn_calls)) begin
          fsm_d = MOVE_UP;
          dir_d = 1'b1;
        end else if (dn_calls) begin
          fsm_d = MOVE_DOWN;
          dir_d = 1'b0;
        end
      end

      MOVE_UP: begin
        if (timer_q == MOVE_LAST) begin
          timer_d = '0;
          if (state_q == TOP) begin
            fsm_d = IDLE;                      // never step past the top floor
          end else begin
            state_d = nxt_up;
            if (|(pending_q & floor_bit(nxt_up))) begin
              fsm_d = DOOR_HOLD;
              clear = floor_bit(nxt_up);
            end else if (!(|(pending_q & above_mask(nxt_up)))) begin
              fsm_d = IDLE;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      MOVE_DOWN: begin
        if (timer_q == MOVE_LAST) begin
          timer_d = '0;
          if (state_q == 3'd0) begin
            fsm_d = IDLE;                      // never step below floor 0
          end else begin
            state_d = nxt_dn;
            if (|(pending_q & floor_bit(nxt_dn))) begin
              fsm_d = DOOR_HOLD;
              clear = floor_bit(nxt_dn);
            end else if (!(|(pending_q & below_mask(nxt_dn)))) begin
              fsm_d = IDLE;
            end
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      DOOR_HOLD: begin
        // A press at the open floor only extends the hold; it is never latched.
        req_eff = req & ~here;
        if (|(req & here)) begin
          timer_d = '0;
        end else if (timer_q == HOLD_LAST) begin
          fsm_d   = IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      default: begin
        fsm_d   = IDLE;
        timer_d = '0;
      end
    endcase

    pending_d = (pending_q | req_eff) & ~clear;
  end

  // State register; outputs are decoded from the next state so they are flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q         <= IDLE;
      dir_q         <= 1'b1;
      timer_q       <= '0;
      state_q       <= 3'd0;
      pending_q     <= '0;
      hold_q        <= 1'b0;
      moving_up_q   <= 1'b0;
      moving_down_q <= 1'b0;
    end else begin
      fsm_q         <= fsm_d;
      dir_q         <= dir_d;
      timer_q       <= timer_d;
      state_q       <= state_d;
      pending_q     <= pending_d;
      hold_q        <= (fsm_d == DOOR_HOLD);
      moving_up_q   <= (fsm_d == MOVE_UP);
      moving_down_q <= (fsm_d == MOVE_DOWN);
    end
  end

  assign state       = state_q;
  assign hold        = hold_q;
  assign moving_up   = moving_up_q;
  assign moving_down = moving_down_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_elevator_controller.sv
// Directed bench for elevator_controller with MOVE_TICKS=4, HOLD_TICKS=3.
module tb_elevator_controller;

  localparam int NF = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NF-1:0] req;
  logic [2:0]    state;
  logic          hold, moving_up, moving_down;
  logic [NF-1:0] pending;

  int n_chk = 0;
  int n_bad = 0;

  elevator_controller #(.NUM_FLOORS(NF), .MOVE_TICKS(4), .HOLD_TICKS(3)) dut (
    .clk(clk), .reset(reset), .req(req), .state(state), .hold(hold),
    .moving_up(moving_up), .moving_down(moving_down), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [14:0] served;
  int          nserved, maxst;
  logic        prev_hold;

  initial begin
    reset = 1'b1;
    req   = '0;

    // 1: reset and idle with no calls
    step(2);
    reset = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_flags", 32'({hold, moving_up, moving_down}), 32'd0);
    chk("rst_pend", 32'(pending), 32'd0);
    for (int i = 0; i < 20; i++) begin
      step(1);
      chk("idle_all", 32'({state, hold, moving_up, moving_down, pending}), 32'd0);
    end

    // 2: call floor 3 from floor 0
    req = 5'b01000;
    step(1);
    req = '0;
    chk("t2_latch", 32'(pending), 32'h08);
    chk("t2_notyet", 32'(moving_up), 32'd0);
    step(1);
    chk("t2_mvup", 32'(moving_up), 32'd1);
    step(3);
    chk("t2_st0", 32'(state), 32'd0);
    step(1);
    chk("t2_st1", 32'(state), 32'd1);
    step(4);
    chk("t2_st2", 32'(state), 32'd2);
    step(4);
    chk("t2_st3", 32'(state), 32'd3);
    chk("t2_hold", 32'({hold, moving_up}), 32'h2);
    chk("t2_clr", 32'(pending), 32'd0);
    step(2);
    chk("t2_hold3", 32'(hold), 32'd1);
    step(1);
    chk("t2_end", 32'({state, hold}), 32'h6);

    // 3: moving up to 4, floor 1 called en route -> reversal
    req = 5'b10000;
    step(1);
    req = '0;
    step(1);
    chk("t3_mvup", 32'(moving_up), 32'd1);
    req = 5'b00010;
    step(1);
    req = '0;
    chk("t3_pend", 32'(pending), 32'h12);
    step(3);
    chk("t3_at4", 32'({state, hold}), 32'h9);
    chk("t3_pend4", 32'(pending), 32'h02);
    step(3);
    chk("t3_idle4", 32'({state, hold, moving_down}), 32'h10);
    step(1);
    chk("t3_mvdn", 32'(moving_down), 32'd1);
    step(4);
    chk("t3_st3", 32'(state), 32'd3);
    step(8);
    chk("t3_at1", 32'({state, hold}), 32'h3);
    chk("t3_pend0", 32'(pending), 32'd0);
    step(3);
    chk("t3_end", 32'(hold), 32'd0);

    // 4: hold extension by pressing the open floor
    req = 5'b00001;
    step(1);
    req = '0;
    step(1);
    chk("t4_mvdn", 32'(moving_down), 32'd1);
    step(4);
    chk("t4_at0", 32'({state, hold}), 32'h1);
    step(1);
    req = 5'b00001;
    step(1);
    req = '0;
    chk("t4_ext0", 32'(hold), 32'd1);
    chk("t4_nolatch", 32'(pending), 32'd0);
    step(1);
    chk("t4_ext1", 32'(hold), 32'd1);
    step(1);
    chk("t4_ext2", 32'(hold), 32'd1);
    step(1);
    chk("t4_done", 32'(hold), 32'd0);
    chk("t4_pend", 32'(pending), 32'd0);
    step(1);
    chk("t4_noreserve", 32'({hold, moving_up, moving_down}), 32'd0);

    // 5: reset while moving down at floor 2
    req = 5'b01000;
    step(1);
    req = '0;
    step(13);
    chk("t5_at3", 32'({state, hold}), 32'h7);
    step(3);
    req = 5'b00001;
    step(1);
    req = '0;
    step(5);
    chk("t5_mid", 32'({state, moving_down}), 32'h5);
    chk("t5_pend", 32'(pending), 32'h01);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("t5_rst", 32'({state, hold, moving_up, moving_down}), 32'd0);
    chk("t5_rstp", 32'(pending), 32'd0);

    // 6: all calls at floor 2, dir up -> 2,3,4,1,0
    req = 5'b00100;
    step(1);
    req = '0;
    step(9);
    chk("t6_at2", 32'({state, hold}), 32'h5);
    step(3);
    req = 5'b11111;
    step(1);
    req = '0;
    chk("t6_all", 32'(pending), 32'h1f);
    served    = '0;
    nserved   = 0;
    maxst     = 0;
    prev_hold = hold;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (hold && !prev_hold) begin
        if (nserved < 5) served = {served[11:0], state};
        nserved++;
      end
      if (int'(state) > maxst) maxst = int'(state);
      prev_hold = hold;
    end
    chk("t6_count", 32'(nserved), 32'd5);
    chk("t6_order", 32'(served), 32'({3'd2, 3'd3, 3'd4, 3'd1, 3'd0}));
    chk("t6_max", 32'(maxst), 32'd4);
    chk("t6_end", 32'({state, hold, moving_up, moving_down, pending}), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
